sys_ctrl: RTL and testbench

- Command sequencer between the UART RX data-sync output and the register file, ALU and TX async FIFO, in the REF_CLK domain.
- Parses framed command bytes (0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands).
- Issues register-file and ALU strobes, gates the ALU clock, and pushes response bytes to the TX FIFO under FIFO-full backpressure.

---
 rtl/sys_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_sys_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
// sys_ctrl: command sequencer between the UART RX byte stream and the
// register file, ALU and TX FIFO (REF_CLK domain).
//
// Frames:  AA addr data        register write
//          BB addr             register read, one response byte
//          CC opA opB fun      write operands to addr 0/1, run ALU, two bytes
//          DD fun              run ALU on stored operands, two bytes
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   RX_P_DATA/RX_D_VLD             received byte and its one-cycle valid
//   RF_RD_DATA/RF_RD_VLD           register-file read response
//   ALU_OUT/ALU_OUT_VLD            ALU result and its valid pulse
//   FIFO_FULL                      TX FIFO full (push withheld while high)
//   RF_ADDR/RF_WR_EN/RF_RD_EN/RF_WR_DATA   register-file access
//   ALU_EN/ALU_FUN/CLK_GATE_EN     ALU control and clock-gate enable
//   TX_P_DATA/TX_D_VLD             TX FIFO push
//   CMD_ERR                        unknown-command pulse
//
// Build option: define SYS_CTRL_ERR_RESP_EN to answer unknown command bytes
// with a CMD_ERR pulse and a 0xEE response byte. Without it such bytes are
// ignored and CMD_ERR is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for a command byte
// WR_ADDR   | waiting for write address
// WR_DATA   | waiting for write data
// RD_ADDR   | waiting for read address
// RD_WAIT   | read strobe issued, waiting for RF_RD_VLD
// ALU_A     | waiting for operand A (written to address 0)
// ALU_B     | waiting for operand B (written to address 1)
// ALU_FUN   | waiting for function code, ALU clock ungated
// ALU_WAIT  | ALU enabled, waiting for ALU_OUT_VLD
// TX_B0     | pushing response byte 0 (LSB)
// TX_B1     | pushing response byte 1 (MSB)

module sys_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
   input  logic                    RX_D_VLD,
   input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
   input  logic                    RF_RD_VLD,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VLD,
   input  logic                    FIFO_FULL,
   output logic [ADDR_WIDTH-1:0]   RF_ADDR,
   output logic                    RF_WR_EN,
   output logic                    RF_RD_EN,
   output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
   output logic                    ALU_EN,
   output logic [FUN_WIDTH-1:0]    ALU_FUN,
   output logic                    CLK_GATE_EN,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   output logic                    CMD_ERR
);

   localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'('hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'('hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'('hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'('hDD);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
      S_ALU_A, S_ALU_B, S_ALU_FUN, S_ALU_WAIT, S_TX_B0, S_TX_B1
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
   logic                    rf_wr_en_q, rf_wr_en_d;
   logic                    rf_rd_en_q, rf_rd_en_d;
   logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
   logic                    alu_en_q, alu_en_d;
   logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
   logic                    clk_gate_q, clk_gate_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic                    tx_vld_q, tx_vld_d;
   logic [2*DATA_WIDTH-1:0] resp_q, resp_d;
   logic                    two_byte_q, two_byte_d;
   logic                    cmd_err_q, cmd_err_d;

   always_comb begin
      state_d      = state_q;
      rf_addr_d    = rf_addr_q;
      rf_wr_en_d   = 1'b0;
      rf_rd_en_d   = 1'b0;
      rf_wr_data_d = rf_wr_data_q;
      alu_en_d     = alu_en_q;
      alu_fun_d    = alu_fun_q;
      clk_gate_d   = clk_gate_q;
      tx_data_d    = tx_data_q;
      tx_vld_d     = 1'b0;
      resp_d       = resp_q;
      two_byte_d   = two_byte_q;
      cmd_err_d    = 1'b0;

      unique case (state_q)
         S_IDLE: if (RX_D_VLD) begin
            if (RX_P_DATA == CMD_WR) begin
               state_d = S_WR_ADDR;
            end else if (RX_P_DATA == CMD_RD) begin
               state_d = S_RD_ADDR;
            end else if (RX_P_DATA == CMD_ALU_OP) begin
               state_d = S_ALU_A;
            end else if (RX_P_DATA == CMD_ALU_NO) begin
               state_d    = S_ALU_FUN;
               clk_gate_d = 1'b1;
            end else begin
`ifdef SYS_CTRL_ERR_RESP_EN
               cmd_err_d  = 1'b1;
               resp_d     = (2*DATA_WIDTH)'('hEE);
               two_byte_d = 1'b0;
               state_d    = S_TX_B0;
`endif
            end
         end
         S_WR_ADDR: if (RX_D_VLD) begin
            rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
            state_d   = S_WR_DATA;
         end
         S_WR_DATA: if (RX_D_VLD) begin
            rf_wr_data_d = RX_P_DATA;
            rf_wr_en_d   = 1'b1;
            state_d      = S_IDLE;
         end
         S_RD_ADDR: if (RX_D_VLD) begin
            rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            rf_rd_en_d = 1'b1;
            state_d    = S_RD_WAIT;
         end
         S_RD_WAIT: if (RF_RD_VLD) begin
            resp_d     = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
            two_byte_d = 1'b0;
            state_d    = S_TX_B0;
         end
         S_ALU_A: if (RX_D_VLD) begin
            rf_addr_d    = '0;
            rf_wr_data_d = RX_P_DATA;
            rf_wr_en_d   = 1'b1;
            state_d      = S_ALU_B;
         end
         S_ALU_B: if (RX_D_VLD) begin
            rf_addr_d    = ADDR_WIDTH'(1);
            rf_wr_data_d = RX_P_DATA;
            rf_wr_en_d   = 1'b1;
            clk_gate_d   = 1'b1;
            state_d      = S_ALU_FUN;
         end
         S_ALU_FUN: if (RX_D_VLD) begin
            alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
            alu_en_d  = 1'b1;
            state_d   = S_ALU_WAIT;
         end
         S_ALU_WAIT: if (ALU_OUT_VLD) begin
            resp_d     = ALU_OUT;
            two_byte_d = 1'b1;
            alu_en_d   = 1'b0;
            clk_gate_d = 1'b0;
            state_d    = S_TX_B0;
         end
         S_TX_B0: begin
            tx_data_d = resp_q[DATA_WIDTH-1:0];
            if (!FIFO_FULL) begin
               tx_vld_d = 1'b1;
               state_d  = two_byte_q ? S_TX_B1 : S_IDLE;
            end
         end
         S_TX_B1: begin
            tx_data_d = resp_q[2*DATA_WIDTH-1:DATA_WIDTH];
            if (!FIFO_FULL) begin
               tx_vld_d = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         rf_addr_q    <= '0;
         rf_wr_en_q   <= 1'b0;
         rf_rd_en_q   <= 1'b0;
         rf_wr_data_q <= '0;
         alu_en_q     <= 1'b0;
         alu_fun_q    <= '0;
         clk_gate_q   <= 1'b0;
         tx_data_q    <= '0;
         tx_vld_q     <= 1'b0;
         resp_q       <= '0;
         two_byte_q   <= 1'b0;
         cmd_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rf_addr_q    <= rf_addr_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_rd_en_q   <= rf_rd_en_d;
         rf_wr_data_q <= rf_wr_data_d;
         alu_en_q     <= alu_en_d;
         alu_fun_q    <= alu_fun_d;
         clk_gate_q   <= clk_gate_d;
         tx_data_q    <= tx_data_d;
         tx_vld_q     <= tx_vld_d;
         resp_q       <= resp_d;
         two_byte_q   <= two_byte_d;
         cmd_err_q    <= cmd_err_d;
      end
   end

   assign RF_ADDR     = rf_addr_q;
   assign RF_WR_EN    = rf_wr_en_q;
   assign RF_RD_EN    = rf_rd_en_q;
   assign RF_WR_DATA  = rf_wr_data_q;
   assign ALU_FUN     = alu_fun_q;
   assign TX_P_DATA   = tx_data_q;
   assign TX_D_VLD    = tx_vld_q;
   assign CMD_ERR     = cmd_err_q;
   // The ALU and its clock are shut off as soon as RST is seen rather than
   // waiting for the reset edge, so an aborted operation never runs on.
   assign ALU_EN      = alu_en_q & ~RST;
   assign CLK_GATE_EN = clk_gate_q & ~RST;

endmodule

// File: tb/tb_sys_ctrl.sv
module tb_sys_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  RX_P_DATA = '0;
   logic        RX_D_VLD = 1'b0;
   logic [7:0]  RF_RD_DATA = '0;
   logic        RF_RD_VLD = 1'b0;
   logic [15:0] ALU_OUT = '0;
   logic        ALU_OUT_VLD = 1'b0;
   logic        FIFO_FULL = 1'b0;
   logic [3:0]  RF_ADDR;
   logic        RF_WR_EN;
   logic        RF_RD_EN;
   logic [7:0]  RF_WR_DATA;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic        CLK_GATE_EN;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        CMD_ERR;

   sys_ctrl dut (
      .CLK(CLK), .RST(RST),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
      .FIFO_FULL(FIFO_FULL),
      .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
      .RF_WR_DATA(RF_WR_DATA),
      .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   int cmd_err_cnt = 0;

   logic [11:0] wr_q[$];
   logic [3:0]  rd_q[$];
   logic [7:0]  tx_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard: every strobe seen must match the oldest expectation
   always @(negedge CLK) begin
      logic [11:0] w;
      if (RF_WR_EN) begin
         if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
         else begin
            w = wr_q.pop_front();
            chk("wr_addr", 32'(RF_ADDR), 32'(w[11:8]));
            chk("wr_data", 32'(RF_WR_DATA), 32'(w[7:0]));
         end
      end
      if (RF_RD_EN) begin
         if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
         else chk("rd_addr", 32'(RF_ADDR), 32'(rd_q.pop_front()));
      end
      if (TX_D_VLD) begin
         if (tx_q.size() == 0) chk("tx_unexpected", 1, 0);
         else chk("tx_data", 32'(TX_P_DATA), 32'(tx_q.pop_front()));
      end
      if (CMD_ERR) cmd_err_cnt++;
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge CLK); #1;
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(posedge CLK); #1;
      RX_D_VLD  = 1'b0;
   endtask

   task automatic wait_alu_en(input string tag);
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge CLK);
         if (ALU_EN) seen = 1;
      end
      if (!seen) chk(tag, 0, 1);
   endtask

   initial begin
      bit seen;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_addr", 32'(RF_ADDR), 0);
      chk("rst_wr_en", 32'(RF_WR_EN), 0);
      chk("rst_tx", 32'({TX_D_VLD, TX_P_DATA}), 0);
      chk("rst_alu", 32'({ALU_EN, ALU_FUN, CLK_GATE_EN}), 0);
      chk("rst_err", 32'(CMD_ERR), 0);
      @(posedge CLK); #1;
      RST = 1'b0;

      // bytes without valid are ignored
      RX_P_DATA = 8'hAA;
      repeat (4) @(posedge CLK);

      // register write
      wr_q.push_back({4'h5, 8'h3C});
      send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
      repeat (5) @(posedge CLK);

      // register read
      rd_q.push_back(4'h5);
      tx_q.push_back(8'h3C);
      send_byte(8'hBB); send_byte(8'h05);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge CLK);
         if (RF_RD_EN) seen = 1;
      end
      if (!seen) chk("rd_en_timeout", 0, 1);
      @(posedge CLK); #1;
      RF_RD_DATA = 8'h3C; RF_RD_VLD = 1'b1;
      @(posedge CLK); #1;
      RF_RD_VLD = 1'b0;
      repeat (6) @(posedge CLK);

      // ALU with operands, minimum response latency
      wr_q.push_back({4'h0, 8'h05});
      wr_q.push_back({4'h1, 8'h07});
      send_byte(8'hCC); send_byte(8'h05); send_byte(8'h07); send_byte(8'h00);
      wait_alu_en("alu_en_timeout_cc");
      chk("alu_fun_cc", 32'(ALU_FUN), 0);
      chk("cg_on_cc", 32'(CLK_GATE_EN), 1);
      repeat (2) @(negedge CLK);
      chk("alu_en_hold", 32'(ALU_EN), 1);
      tx_q.push_back(8'h0C);
      tx_q.push_back(8'h00);
      @(posedge CLK); #1;
      ALU_OUT = 16'h000C; ALU_OUT_VLD = 1'b1;
      @(negedge CLK);
      chk("cg_at_vld", 32'(CLK_GATE_EN), 1);
      @(posedge CLK); #1;
      ALU_OUT_VLD = 1'b0;
      @(negedge CLK);
      chk("alu_en_drop", 32'(ALU_EN), 0);
      chk("cg_drop", 32'(CLK_GATE_EN), 0);
      chk("lat_early", 32'(TX_D_VLD), 0);
      @(negedge CLK);
      chk("lat_min", 32'(TX_D_VLD), 1);
      repeat (6) @(posedge CLK);

      // ALU without operands, backpressure
      @(negedge CLK);
      chk("cg_idle", 32'(CLK_GATE_EN), 0);
      send_byte(8'hDD);
      chk("cg_entry", 32'(CLK_GATE_EN), 1);
      send_byte(8'h01);
      wait_alu_en("alu_en_timeout_dd");
      chk("alu_fun_dd", 32'(ALU_FUN), 1);
      @(posedge CLK); #1;
      FIFO_FULL = 1'b1;
      ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
      @(posedge CLK); #1;
      ALU_OUT_VLD = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk("tx_while_full", 32'(TX_D_VLD), 0);
      end
      tx_q.push_back(8'h34);
      tx_q.push_back(8'h12);
      @(posedge CLK); #1;
      FIFO_FULL = 1'b0;
      repeat (8) @(posedge CLK);
      chk("tx_full_drained", 32'(tx_q.size()), 0);

      // unknown command byte
`ifdef SYS_CTRL_ERR_RESP_EN
      tx_q.push_back(8'hEE);
`endif
      send_byte(8'h55);
      repeat (6) @(posedge CLK);
      @(negedge CLK);
`ifdef SYS_CTRL_ERR_RESP_EN
      chk("cmd_err_cnt", 32'(cmd_err_cnt), 1);
      chk("unk_tx_data", 32'(TX_P_DATA), 32'h EE);
`else
      chk("cmd_err_cnt", 32'(cmd_err_cnt), 0);
      chk("unk_tx_data", 32'(TX_P_DATA), 32'h12);
`endif
      chk("unk_addr", 32'(RF_ADDR), 1);
      chk("unk_fun", 32'(ALU_FUN), 1);

      // reset in the middle of a write frame
      send_byte(8'hAA); send_byte(8'h05);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("midrst_addr", 32'(RF_ADDR), 0);
      chk("midrst_wr_en", 32'(RF_WR_EN), 0);
      wr_q.push_back({4'h2, 8'h11});
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
      repeat (6) @(posedge CLK);

      chk("wr_left", 32'(wr_q.size()), 0);
      chk("rd_left", 32'(rd_q.size()), 0);
      chk("tx_left", 32'(tx_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
